// File: rtl/mux_nto1_scan.sv
// N-channel registered multiplexer with static, scan and masked round-robin
// selection, driving a single valid/ready consumer.

module mux_nto1_scan_lane #(
  parameter int SEL_W = 3,
  parameter int K     = 0
) (
  input  logic [SEL_W-1:0] ptr,
  input  logic             mask_bit,
  output logic             hi_hit
);
  localparam logic [SEL_W-1:0] KV = SEL_W'(K);

  // Enabled channel at or above the pointer: wins before any wrapped channel.
  assign hi_hit = mask_bit && (KV >= ptr);
endmodule

module mux_nto1_scan #(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [N_CH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      ch_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);
  localparam logic [SEL_W:0]   NCH_W = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] ch_out_q, ch_out_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N_CH-1:0]  hi_hit;
  logic             hi_any;
  logic [SEL_W-1:0] mk_ch;
  logic [SEL_W-1:0] ch;
  logic             have;
  logic             free;
  logic             capture;
  logic [WIDTH-1:0] sel_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mux_nto1_scan_lane #(.SEL_W(SEL_W), .K(k)) u_lane (
      .ptr      (ptr_q),
      .mask_bit (ch_mask[k]),
      .hi_hit   (hi_hit[k])
    );
  end

  // Lowest hit above ptr, otherwise lowest enabled channel overall (wrap).
  always_comb begin
    hi_any = |hi_hit;
    mk_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hi_any ? hi_hit[i] : ch_mask[i]) mk_ch = SEL_W'(i);
    end
  end

  always_comb begin
    free      = !out_valid_q || out_ready;
    ch        = '0;
    have      = 1'b0;
    sel_err_d = 1'b0;
    case (mode)
      2'b00: begin
        if ({1'b0, sel_in} < NCH_W) begin
          have = 1'b1;
          ch   = sel_in;
        end else begin
          sel_err_d = free && en;
        end
      end
      2'b01: begin
        have = 1'b1;
        ch   = ptr_q;
      end
      2'b10: begin
        have = |ch_mask;
        ch   = mk_ch;
      end
      default: ;
    endcase
    capture = free && en && have;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch == SEL_W'(i)) sel_data = din[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    dout_d      = dout_q;
    ch_out_d    = ch_out_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (capture) begin
      dout_d      = sel_data;
      ch_out_d    = ch;
      out_valid_d = 1'b1;
      // In scan mode ch == ptr, so one advance rule serves both scan modes.
      if (mode != 2'b00) ptr_d = (ch == LAST) ? '0 : ch + SEL_W'(1);
    end else if (free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      ch_out_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      dout_q      <= dout_d;
      ch_out_q    <= ch_out_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign dout      = dout_q;
  assign ch_out    = ch_out_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench: an 8x1 instance for static/masked tests, a 5x4 instance for
// scan wrap, stall, out-of-range select and asynchronous reset.

module tb_mux_nto1_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8 channels x 1 bit
  logic       rst8_n, en8, rdy8;
  logic [1:0] mode8;
  logic [2:0] sel8, ch8;
  logic [7:0] mask8, din8;
  logic       dout8, vld8, err8;

  // 5 channels x 4 bits
  logic        rst5_n, en5, rdy5;
  logic [1:0]  mode5;
  logic [2:0]  sel5, ch5;
  logic [4:0]  mask5;
  logic [19:0] din5;
  logic [3:0]  dout5;
  logic        vld5, err5;

  int checks = 0;
  int errors = 0;

  mux_nto1_scan #(.N_CH(8), .WIDTH(1)) dut8 (
    .clk(clk), .rst_n(rst8_n), .en(en8), .mode(mode8), .sel_in(sel8),
    .ch_mask(mask8), .din(din8), .dout(dout8), .ch_out(ch8),
    .out_valid(vld8), .out_ready(rdy8), .sel_err(err8)
  );

  mux_nto1_scan #(.N_CH(5), .WIDTH(4)) dut5 (
    .clk(clk), .rst_n(rst5_n), .en(en5), .mode(mode5), .sel_in(sel5),
    .ch_mask(mask5), .din(din5), .dout(dout5), .ch_out(ch5),
    .out_valid(vld5), .out_ready(rdy5), .sel_err(err5)
  );

  typedef struct {
    logic [2:0] sel;
    logic       dout;
    logic [2:0] ch;
  } st_vec_t;

  typedef struct {
    logic [7:0] mask;
    logic       valid;
    logic       dout;
    logic [2:0] ch;
  } mk_vec_t;

  st_vec_t st_tab[8];
  mk_vec_t mk_tab[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [19:0] DIN5 = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3};

  initial begin
    // din8 = 8'b11010011 -> channel values 1,1,0,0,1,0,1,1
    st_tab[0] = '{3'd0, 1'b1, 3'd0};
    st_tab[1] = '{3'd1, 1'b1, 3'd1};
    st_tab[2] = '{3'd2, 1'b0, 3'd2};
    st_tab[3] = '{3'd3, 1'b0, 3'd3};
    st_tab[4] = '{3'd4, 1'b1, 3'd4};
    st_tab[5] = '{3'd5, 1'b0, 3'd5};
    st_tab[6] = '{3'd6, 1'b1, 3'd6};
    st_tab[7] = '{3'd7, 1'b1, 3'd7};
    mk_tab[0] = '{8'b10100100, 1'b1, 1'b0, 3'd2};
    mk_tab[1] = '{8'b10100100, 1'b1, 1'b0, 3'd5};
    mk_tab[2] = '{8'b10100100, 1'b1, 1'b1, 3'd7};
    mk_tab[3] = '{8'b10100100, 1'b1, 1'b0, 3'd2};
    mk_tab[4] = '{8'b10100100, 1'b1, 1'b0, 3'd5};
    mk_tab[5] = '{8'b10100100, 1'b1, 1'b1, 3'd7};
    mk_tab[6] = '{8'b00000000, 1'b0, 1'b0, 3'd0};
    mk_tab[7] = '{8'b00000000, 1'b0, 1'b0, 3'd0};
    mk_tab[8] = '{8'b11111111, 1'b1, 1'b1, 3'd0};  // ptr held at 0 after wrap

    rst8_n = 1'b0; en8 = 1'b0; rdy8 = 1'b1; mode8 = 2'b00; sel8 = '0;
    mask8 = '0; din8 = 8'b11010011;
    rst5_n = 1'b0; en5 = 1'b0; rdy5 = 1'b1; mode5 = 2'b00; sel5 = '0;
    mask5 = '0; din5 = DIN5;
    #12;
    chk("rst dout8", 32'(dout8), 32'd0);
    chk("rst ch8", 32'(ch8), 32'd0);
    chk("rst vld8", 32'(vld8), 32'd0);
    chk("rst err8", 32'(err8), 32'd0);
    chk("rst vld5", 32'(vld5), 32'd0);
    rst8_n = 1'b1; rst5_n = 1'b1;
    tick();

    // Static select sweep
    en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel8 = st_tab[i].sel;
      tick();
      chk($sformatf("static dout[%0d]", i), 32'(dout8), 32'(st_tab[i].dout));
      chk($sformatf("static ch[%0d]", i), 32'(ch8), 32'(st_tab[i].ch));
      chk($sformatf("static vld[%0d]", i), 32'(vld8), 32'd1);
      chk($sformatf("static err[%0d]", i), 32'(err8), 32'd0);
    end

    // Masked scan, then empty mask, then full mask from the held pointer
    mode8 = 2'b10;
    for (int i = 0; i < 9; i++) begin
      mask8 = mk_tab[i].mask;
      tick();
      chk($sformatf("mask vld[%0d]", i), 32'(vld8), 32'(mk_tab[i].valid));
      if (mk_tab[i].valid) begin
        chk($sformatf("mask ch[%0d]", i), 32'(ch8), 32'(mk_tab[i].ch));
        chk($sformatf("mask dout[%0d]", i), 32'(dout8), 32'(mk_tab[i].dout));
      end
    end

    // Scan wrap on 5 channels
    en5 = 1'b1; mode5 = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("scan ch[%0d]", i), 32'(ch5), 32'(i % 5));
      chk($sformatf("scan dout[%0d]", i), 32'(dout5), 32'(i % 5 + 3));
      chk($sformatf("scan vld[%0d]", i), 32'(vld5), 32'd1);
    end

    // Idle drains the pending sample
    mode5 = 2'b11;
    tick();
    chk("idle vld", 32'(vld5), 32'd0);

    // Out-of-range static select
    mode5 = 2'b00; sel5 = 3'd6;
    tick();
    chk("oor err", 32'(err5), 32'd1);
    chk("oor vld", 32'(vld5), 32'd0);
    sel5 = 3'd2;
    tick();
    chk("oor err clr", 32'(err5), 32'd0);
    chk("static5 ch", 32'(ch5), 32'd2);
    chk("static5 dout", 32'(dout5), 32'd5);
    en5 = 1'b0; sel5 = 3'd6;
    tick();
    chk("oor en0 err", 32'(err5), 32'd0);
    chk("oor en0 vld", 32'(vld5), 32'd0);
    en5 = 1'b1; sel5 = 3'd2; rdy5 = 1'b0;
    tick();
    chk("stall pre vld", 32'(vld5), 32'd1);
    sel5 = 3'd6;
    tick();
    chk("oor stall err", 32'(err5), 32'd0);
    chk("oor stall vld", 32'(vld5), 32'd1);
    chk("oor stall ch", 32'(ch5), 32'd2);

    // Fresh start, then stall with din changing underneath
    #2; rst5_n = 1'b0; #1; rst5_n = 1'b1;
    mode5 = 2'b01; rdy5 = 1'b0;
    tick();
    chk("stall first ch", 32'(ch5), 32'd0);
    chk("stall first dout", 32'(dout5), 32'd3);
    din5 = 20'hFFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall ch[%0d]", i), 32'(ch5), 32'd0);
      chk($sformatf("stall dout[%0d]", i), 32'(dout5), 32'd3);
      chk($sformatf("stall vld[%0d]", i), 32'(vld5), 32'd1);
    end
    din5 = DIN5; rdy5 = 1'b1;
    tick();
    chk("resume ch", 32'(ch5), 32'd1);
    chk("resume dout", 32'(dout5), 32'd4);
    rdy5 = 1'b0;
    tick();
    chk("hold ch", 32'(ch5), 32'd1);
    chk("hold vld", 32'(vld5), 32'd1);

    // Asynchronous reset mid-stall
    #3; rst5_n = 1'b0; #1;
    chk("arst dout", 32'(dout5), 32'd0);
    chk("arst ch", 32'(ch5), 32'd0);
    chk("arst vld", 32'(vld5), 32'd0);
    chk("arst err", 32'(err5), 32'd0);
    #2; rst5_n = 1'b1; rdy5 = 1'b1;
    tick();
    chk("post rst ch", 32'(ch5), 32'd0);
    chk("post rst dout", 32'(dout5), 32'd3);
    chk("post rst vld", 32'(vld5), 32'd1);
    tick();
    chk("post rst ch2", 32'(ch5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
